// File: rtl/sequencia_pkg.sv
// Shared types and helpers for the 0,1,1 pattern checker.
// Phase encoding and the expected bit for each phase live here.
package sequencia_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        LOCKED
    } estado_t;

    localparam logic [1:0] F0 = 2'd0;
    localparam logic [1:0] F1 = 2'd1;
    localparam logic [1:0] F2 = 2'd2;

    // Pattern period is 0,1,1: only phase 0 expects a zero.
    function automatic logic bit_esperado(input logic [1:0] fase);
        return fase != F0;
    endfunction

    function automatic logic [1:0] proxima_fase(input logic [1:0] fase);
        return (fase == F2) ? F0 : fase + 2'd1;
    endfunction

endpackage

// File: rtl/contador_sat.sv
// Up-counter with increment enable; SATURA selects saturate-at-all-ones
// instead of wrapping modulo 2^CNT_W.
module contador_sat #(
    parameter int CNT_W  = 8,
    parameter bit SATURA = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] valor
);

    logic cheio;
    assign cheio = SATURA && (&valor);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (inc && !cheio) begin
            valor <= valor + 1'b1;
        end
    end

endmodule

// File: rtl/verificador_sequencia.sv
// Serial checker for the repeating 0,1,1 pattern: acquires phase, locks after
// LOCK_N clean periods, flags mismatches and drops lock after LOSS_N in a row.
module verificador_sequencia
    import sequencia_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 2,
    parameter int LOSS_N = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_in,
    input  logic             en,
    output logic             locked,
    output logic [1:0]       fase,
    output logic             erro,
    output logic [CNT_W-1:0] periodos,
    output logic [CNT_W-1:0] erros
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(LOSS_N + 1);
    localparam logic [GW-1:0] LOCK_ALVO = GW'(LOCK_N);
    localparam logic [BW-1:0] LOSS_ALVO = BW'(LOSS_N);

    estado_t       estado;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic          limpo;

    logic          acerto;
    logic          limpo_prox;
    logic [GW-1:0] good_prox;
    logic [BW-1:0] bad_prox;
    logic          amostra_locked;
    logic          inc_periodo;
    logic          inc_erro;

    assign acerto         = (s_in == bit_esperado(fase));
    assign good_prox      = good_cnt + 1'b1;
    assign bad_prox       = bad_cnt + 1'b1;
    assign amostra_locked = en && (estado == LOCKED);

    // A period counts only if none of its three bits mismatched.
    assign limpo_prox  = (fase == F0) ? acerto : (limpo && acerto);
    assign inc_periodo = amostra_locked && (fase == F2) && limpo_prox;
    assign inc_erro    = amostra_locked && !acerto;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, like the real flops do.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= SEARCH;
            fase     <= F0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            limpo    <= 1'b0;
            locked   <= 1'b0;
            erro     <= 1'b0;
        end else begin
            erro <= 1'b0;
            if (en) begin
                unique case (estado)
                    SEARCH: begin
                        if (!s_in) begin
                            fase     <= F1;
                            good_cnt <= '0;
                            estado   <= TRAIN;
                        end
                    end
                    TRAIN: begin
                        if (acerto) begin
                            fase <= proxima_fase(fase);
                            if (fase == F2) begin
                                good_cnt <= good_prox;
                                if (good_prox == LOCK_ALVO) begin
                                    estado  <= LOCKED;
                                    locked  <= 1'b1;
                                    bad_cnt <= '0;
                                end
                            end
                        end else begin
                            good_cnt <= '0;
                            if (!s_in) begin
                                fase <= F1;
                            end else begin
                                fase   <= F0;
                                estado <= SEARCH;
                            end
                        end
                    end
                    LOCKED: begin
                        limpo <= limpo_prox;
                        if (acerto) begin
                            bad_cnt <= '0;
                            fase    <= proxima_fase(fase);
                        end else begin
                            erro <= 1'b1;
                            if (bad_prox == LOSS_ALVO) begin
                                estado  <= SEARCH;
                                fase    <= F0;
                                locked  <= 1'b0;
                                bad_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_prox;
                                fase    <= proxima_fase(fase);
                            end
                        end
                    end
                    default: estado <= SEARCH;
                endcase
            end
        end
    end

    contador_sat #(.CNT_W(CNT_W), .SATURA(1'b0)) u_periodos (
        .clock (clock),
        .reset (reset),
        .inc   (inc_periodo),
        .valor (periodos)
    );

    contador_sat #(.CNT_W(CNT_W), .SATURA(1'b1)) u_erros (
        .clock (clock),
        .reset (reset),
        .inc   (inc_erro),
        .valor (erros)
    );

endmodule

// File: doc/verificador_sequencia.md
# verificador_sequencia

Serial checker directly downstream of the 3-state pattern generator. It samples the generator's output bit, which repeats the period 0,1,1. The block acquires phase alignment and declares lock after a run of good periods. While locked it counts completed periods and flags and counts mismatches. It drops lock after consecutive mismatches, giving the rest of the design a single "pattern healthy" indicator plus diagnostic counters.

## Interface
- CNT_W, 8: width of the period and error counters
- LOCK_N, 2: consecutive correct periods needed to declare lock (≥1)
- LOSS_N, 2: consecutive mismatched bits that drop lock (≥1)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- s_in  input  1  serial bit from the pattern generator
- en  input  1  sample strobe; s_in is evaluated only when en=1
- locked  output  1  high while in LOCKED
- fase  output  2  phase (0,1,2) of the next expected bit; 0 in SEARCH
- erro  output  1  one-cycle pulse per mismatch detected in LOCKED
- periodos  output  CNT_W  correct periods completed while LOCKED; wraps
- erros  output  CNT_W  mismatches detected while LOCKED; saturates at all-ones

## Operation
- Reset is asynchronous, active-low. It forces state SEARCH and sets all of the following to 0: fase, good count, bad count, locked, erro, periodos, erros.
- Expected bit by phase: phase 0 → 0, phase 1 → 1, phase 2 → 1. Phase advances 0→1→2→0 on every en sample outside SEARCH.
- With en=0, all state holds and erro=0.
- SEARCH:
  - s_in=1 is ignored.
  - s_in=0 is the anchor, taken as phase 0 of period 1. The block sets fase=1, clears the good count and goes to TRAIN.
- TRAIN:
  - A match at phase 2 increments the good count.
  - When the good count reaches LOCK_N, the block goes to LOCKED. The locking period is not counted in periodos.
  - On a mismatch, the good count clears and no erro pulse is produced:
    - mismatching bit 0: re-anchor with fase=1 and stay in TRAIN;
    - mismatching bit 1: go to SEARCH.
- LOCKED:
  - A match clears the bad count. A match at phase 2 increments periodos, wrapping modulo 2^CNT_W.
  - A mismatch pulses erro, increments erros (saturating) and increments the bad count. Phase keeps advancing (flywheel).
  - When the bad count reaches LOSS_N, the block goes to SEARCH and fase=0. In that same sample, erro still pulses and erros still increments.
- periodos and erros are cleared only by reset. They hold their values through lock loss and re-acquisition.

## Timing
- All outputs are registered. Each responds in the cycle after the rising edge that sampled en=1.
- Latency from the final bit of period LOCK_N to locked=1 is 1 clock.
- erro is high for exactly one clock per mismatching sample. With back-to-back en, consecutive mismatches give consecutive erro pulses.
- On lock loss, locked falls in the same cycle that the final erro pulse is visible.
- If reset is asserted mid-operation, outputs clear immediately (asynchronously). The first en sample after release is treated as in SEARCH.
- en may be held high continuously or pulsed sparsely. Behaviour depends only on the sequence of sampled bits.

## Structure
- Package sequencia_pkg holds:
  - typedef enum logic [1:0] estado_t {SEARCH, TRAIN, LOCKED};
  - phase constants F0=0, F1=1, F2=2;
  - function bit_esperado(fase) returning the expected bit.
- One sub-module, contador_sat: a parameterised CNT_W counter with increment enable and a saturate/wrap select. It is instantiated twice:
  - periodos in wrap mode;
  - erros in saturate mode.
- The FSM, phase register and good/bad counters live in the top module.

## Test plan
- Acquisition: after reset, en=1 every cycle, bits 1,0,1,1,0,1,1 → locked=1 the cycle after the 7th sample; periodos=0, erros=0, fase=0.
- Period counting: locked, feed 4 more periods (0,1,1 ×4) → periodos=4; erro never asserted; locked stays 1.
- Single error tolerance: locked, feed 0,0,1,0,1,1 → one erro pulse after the 2nd bit; erros=1; locked stays 1. periodos does not increment for the corrupted period and increments for the following good one.
- Lock loss and re-anchor: locked, feed 0,0,0 → erro pulses on the 2nd and 3rd bits; erros=+2; locked=0 after the 3rd bit. Then feed 0,1,1,0,1,1 → locked=1 again; counters retained.
- TRAIN re-anchor and en gaps: from reset, feed 0,1,0,1,1,0,1,1 with en toggling 1,0 between samples → the 0 at position 3 re-anchors; lock occurs after the final sample; no erro pulses.
- Saturation/wrap with CNT_W=2: force 5 lock-phase mismatches across re-locks → erros=3. Run 5 locked periods → periodos=1. Assert reset mid-period → all outputs 0 immediately.
